// File: rtl/hub75_capture.sv
// hub75_capture
//   Receive side of the HUB75 panel link. All HUB75 pins are sampled through a
//   common synchroniser on the local clock. Each row of serial colour data is
//   reassembled, and on every latch a row record is emitted. The record holds
//   the row bits, the row address, a bit-plane slot index, a flag for a wrong
//   shift count, and the output-enable on-time measured since the previous latch.
//
// Ports
//   clk, rst_n    local sample clock, async active-low reset
//   hub_clk       HUB75 shift clock (data sampled on its rising edge)
//   hub_lat       HUB75 latch, active high
//   hub_noe       HUB75 output enable, active low
//   hub_mux       HUB75 row address
//   s_in          serial colour data, bit i = colour i
//   out_valid     one-cycle pulse per latched row record
//   out_data      row bits, bit (COLOR_COUNT*j + i) = column j, colour i
//   out_row       synced hub_mux at the latch edge
//   out_slot      latch index within the current row
//   out_on_cycles clk cycles with hub_noe low since the previous latch edge
//   out_bad_count shift count since the previous latch was not NUM_COL
module hub75_capture #(
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int COLOR_COUNT   = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int SLOT_BITS     = 4,
  parameter int DUR_BITS      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        hub_clk,
  input  logic                                        hub_lat,
  input  logic                                        hub_noe,
  input  logic [ROW_ADDR_BITS-1:0]                    hub_mux,
  input  logic [COLOR_COUNT-1:0]                      s_in,
  output logic                                        out_valid,
  output logic [(2**COL_ADDR_BITS)*COLOR_COUNT-1:0]   out_data,
  output logic [ROW_ADDR_BITS-1:0]                    out_row,
  output logic [SLOT_BITS-1:0]                        out_slot,
  output logic [DUR_BITS-1:0]                         out_on_cycles,
  output logic                                        out_bad_count
);

  localparam int NUM_COL = 2**COL_ADDR_BITS;
  localparam int SW      = 3 + ROW_ADDR_BITS + COLOR_COUNT;
  // Idle pin state: clk/lat low, noe high (display off), mux/data zero.
  localparam logic [SW-1:0] IDLE = {1'b0, 1'b0, 1'b1, {(ROW_ADDR_BITS+COLOR_COUNT){1'b0}}};
  localparam logic [COL_ADDR_BITS:0] BC_FULL = (COL_ADDR_BITS+1)'(NUM_COL);
  localparam logic [COL_ADDR_BITS:0] BC_MAX  = (COL_ADDR_BITS+1)'(NUM_COL+1);

  // One packed vector through the synchroniser keeps every pin mutually aligned.
  logic [SW-1:0]              r_sync [SYNC_STAGES];
  logic                       r_hist_clk;
  logic                       r_hist_lat;
  logic [NUM_COL-1:0]         r_sr [COLOR_COUNT];
  logic [COL_ADDR_BITS:0]     r_bit_cnt;
  logic [DUR_BITS-1:0]        r_noe_cnt;
  logic                       r_have_prev;

  logic [SW-1:0]              w_pins;
  logic [SW-1:0]              w_s;
  logic                       w_clk_s;
  logic                       w_lat_s;
  logic                       w_noe_s;
  logic [ROW_ADDR_BITS-1:0]   w_mux_s;
  logic [COLOR_COUNT-1:0]     w_din_s;
  logic                       w_clk_rise;
  logic                       w_lat_rise;
  logic [NUM_COL-1:0]         w_sr_next [COLOR_COUNT];
  logic [COL_ADDR_BITS:0]     w_bit_cnt_next;
  logic [DUR_BITS-1:0]        w_noe_next;
  logic [NUM_COL*COLOR_COUNT-1:0] w_data;
  logic [SLOT_BITS-1:0]       w_slot_next;

  assign w_pins  = {hub_clk, hub_lat, hub_noe, hub_mux, s_in};
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_clk_s = w_s[SW-1];
  assign w_lat_s = w_s[SW-2];
  assign w_noe_s = w_s[SW-3];
  assign w_mux_s = w_s[COLOR_COUNT +: ROW_ADDR_BITS];
  assign w_din_s = w_s[COLOR_COUNT-1:0];

  assign w_clk_rise = w_clk_s & ~r_hist_clk;
  assign w_lat_rise = w_lat_s & ~r_hist_lat;

  // The shift is resolved before the latch uses it, so a bit clocked in the
  // same sample as the latch edge is part of the reported row.
  always_comb begin
    for (int c = 0; c < COLOR_COUNT; c++) begin
      w_sr_next[c] = r_sr[c];
      if (w_clk_rise) w_sr_next[c] = {r_sr[c][NUM_COL-2:0], w_din_s[c]};
    end
    w_data = '0;
    for (int j = 0; j < NUM_COL; j++)
      for (int c = 0; c < COLOR_COUNT; c++)
        w_data[COLOR_COUNT*j + c] = w_sr_next[c][j];
  end

  always_comb begin
    w_bit_cnt_next = r_bit_cnt;
    if (w_clk_rise && (r_bit_cnt != BC_MAX)) w_bit_cnt_next = r_bit_cnt + 1'b1;
    w_noe_next = r_noe_cnt;
    if (!w_noe_s && (r_noe_cnt != '1)) w_noe_next = r_noe_cnt + 1'b1;
    // out_row/out_slot hold the previous record, so they double as slot state.
    w_slot_next = '0;
    if (r_have_prev && (w_mux_s == out_row))
      w_slot_next = (out_slot == '1) ? out_slot : out_slot + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= IDLE;
      r_hist_clk <= 1'b0;
      r_hist_lat <= 1'b0;
    end else begin
      r_sync[0] <= w_pins;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist_clk <= w_clk_s;
      r_hist_lat <= w_lat_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLOR_COUNT; c++) r_sr[c] <= '0;
      r_bit_cnt     <= '0;
      r_noe_cnt     <= '0;
      r_have_prev   <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      out_slot      <= '0;
      out_on_cycles <= '0;
      out_bad_count <= 1'b0;
    end else begin
      r_sr      <= w_sr_next;
      out_valid <= w_lat_rise;
      if (w_lat_rise) begin
        out_data      <= w_data;
        out_row       <= w_mux_s;
        out_slot      <= w_slot_next;
        out_on_cycles <= w_noe_next;
        out_bad_count <= (w_bit_cnt_next != BC_FULL);
        r_have_prev   <= 1'b1;
        r_bit_cnt     <= '0;
        r_noe_cnt     <= '0;
      end else begin
        r_bit_cnt <= w_bit_cnt_next;
        r_noe_cnt <= w_noe_next;
      end
    end
  end

endmodule

// File: tb/tb_hub75_capture.sv
module tb_hub75_capture;

  localparam int NC = 8;
  localparam int CC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hub_clk = 1'b0;
  logic       hub_lat = 1'b0;
  logic       hub_noe = 1'b1;
  logic [3:0] hub_mux = '0;
  logic [2:0] s_in = '0;

  logic        a_valid, a_bad, b_valid, b_bad;
  logic [23:0] a_data, b_data;
  logic [3:0]  a_row, a_slot, b_row, b_slot;
  logic [15:0] a_on;
  logic [3:0]  b_on;

  hub75_capture #(.COL_ADDR_BITS(3), .ROW_ADDR_BITS(4), .COLOR_COUNT(3),
                  .SYNC_STAGES(2), .SLOT_BITS(4), .DUR_BITS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_noe(hub_noe), .hub_mux(hub_mux), .s_in(s_in),
    .out_valid(a_valid), .out_data(a_data), .out_row(a_row),
    .out_slot(a_slot), .out_on_cycles(a_on), .out_bad_count(a_bad));

  hub75_capture #(.COL_ADDR_BITS(3), .ROW_ADDR_BITS(4), .COLOR_COUNT(3),
                  .SYNC_STAGES(2), .SLOT_BITS(4), .DUR_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_lat(hub_lat),
    .hub_noe(hub_noe), .hub_mux(hub_mux), .s_in(s_in),
    .out_valid(b_valid), .out_data(b_data), .out_row(b_row),
    .out_slot(b_slot), .out_on_cycles(b_on), .out_bad_count(b_bad));

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data; logic [3:0] row; logic [3:0] slot; logic bad;
    logic [15:0] on_a; logic [3:0] on_b;
  } act_t;
  typedef struct {
    logic [23:0] data; logic [3:0] row; logic [3:0] slot; logic bad; int on;
  } exp_t;

  act_t act_q[$];
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Pin-level reference model state.
  logic [2:0] m_hist[$];
  int m_shifts, m_noe, m_slot, m_prev_row;
  bit m_have_prev, m_pclk, m_plat, noe_rand;

  always @(negedge clk)
    if (a_valid) act_q.push_back('{a_data, a_row, a_slot, a_bad, a_on, b_on});

  task automatic model_reset();
    m_hist.delete();
    m_shifts = 0; m_noe = 0; m_slot = 0; m_prev_row = 0;
    m_have_prev = 0; m_pclk = 0; m_plat = 0;
  endtask

  // Observes the pins exactly as the next clk edge will sample them.
  task automatic model_sample();
    exp_t e;
    if (!rst_n) return;
    if (hub_noe == 1'b0) m_noe++;
    if (hub_clk && !m_pclk) begin
      m_hist.push_back(s_in);
      if (m_hist.size() > NC) void'(m_hist.pop_front());
      m_shifts++;
    end
    if (hub_lat && !m_plat) begin
      e.data = '0;
      for (int j = 0; j < NC; j++) begin
        int idx = m_hist.size() - 1 - j;
        if (idx >= 0) e.data[CC*j +: CC] = m_hist[idx];
      end
      if (!m_have_prev || int'(hub_mux) != m_prev_row) m_slot = 0;
      else if (m_slot < 15) m_slot++;
      e.row = hub_mux; e.slot = 4'(m_slot); e.bad = (m_shifts != NC); e.on = m_noe;
      exp_q.push_back(e);
      m_have_prev = 1; m_prev_row = int'(hub_mux); m_shifts = 0; m_noe = 0;
    end
    m_pclk = hub_clk; m_plat = hub_lat;
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk); #1;
    if (noe_rand) hub_noe = 1'($urandom_range(0, 1));
  endtask

  task automatic shift_bit(input logic [2:0] d);
    s_in = d; hub_clk = 1'b1; tick(); tick();
    hub_clk = 1'b0; tick(); tick();
  endtask

  task automatic latch(input logic [3:0] mux, input int hold);
    hub_mux = mux; hub_lat = 1'b1;
    repeat (hold) tick();
    hub_lat = 1'b0;
    repeat (3) tick();
  endtask

  task automatic clear_q();
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (3) tick();
    n_total++;
    if ({a_valid, a_data, a_row, a_slot, a_on, a_bad, b_valid, b_data, b_row, b_slot, b_on, b_bad} !== '0)
      $display("FAIL reset_outputs: got a_data=%h a_row=%h a_slot=%h a_on=%h got_valid=%b required all zero",
               a_data, a_row, a_slot, a_on, a_valid);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'b1011_0010;
    logic [7:0] got0;
    act_t a; exp_t e;
    clear_q();
    for (int k = 7; k >= 0; k--) shift_bit({2'b00, pat[k]});
    hub_mux = 4'd5; hub_lat = 1'b1;
    tick(); tick();
    n_total++;
    if (a_valid !== 1'b0) $display("FAIL latency_early: got valid=%b required 0", a_valid); else n_pass++;
    tick();
    n_total++;
    if (a_valid !== 1'b1) $display("FAIL latency_edge3: got valid=%b required 1", a_valid); else n_pass++;
    tick();
    n_total++;
    if (a_valid !== 1'b0) $display("FAIL latency_edge4: got valid=%b required 0", a_valid); else n_pass++;
    hub_lat = 1'b0; repeat (3) tick();
    n_total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      $display("FAIL basic_count: got %0d records required 1", act_q.size());
      return;
    end
    n_pass++;
    a = act_q.pop_front(); e = exp_q.pop_front();
    for (int j = 0; j < 8; j++) got0[j] = a.data[CC*j];
    n_total++;
    if (got0 !== pat || a.data !== e.data)
      $display("FAIL basic_data: got %h required colour0 %b (data %h)", a.data, pat, e.data);
    else n_pass++;
    n_total++;
    if (a.row !== 4'd5 || a.slot !== 4'd0 || a.bad !== 1'b0)
      $display("FAIL basic_fields: got row=%0d slot=%0d bad=%b required 5 0 0", a.row, a.slot, a.bad);
    else n_pass++;
  endtask

  task automatic test_slot();
    logic [3:0] rows [5] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
    logic [3:0] want [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    act_t a; exp_t e;
    latch(4'd2, 2);
    clear_q();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NC; k++) shift_bit(3'($urandom));
      latch(rows[r], 2);
    end
    n_total++;
    if (act_q.size() != 5 || exp_q.size() != 5) begin
      $display("FAIL slot_count: got %0d records required 5", act_q.size());
      return;
    end
    n_pass++;
    for (int r = 0; r < 5; r++) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_total++;
      if (a.slot !== want[r] || a.slot !== e.slot || a.data !== e.data || a.row !== rows[r])
        $display("FAIL slot_seq%0d: got slot=%0d row=%0d required slot=%0d row=%0d", r, a.slot, a.row, want[r], rows[r]);
      else n_pass++;
    end
    repeat (17) latch(4'd9, 2);
    n_total++;
    if (act_q.size() != 17) $display("FAIL slot_sat_count: got %0d records required 17", act_q.size());
    else begin
      a = act_q[16]; e = exp_q[16];
      if (a.slot !== 4'd15 || e.slot !== 4'd15) $display("FAIL slot_sat: got %0d required 15", a.slot);
      else n_pass++;
    end
    clear_q();
  endtask

  task automatic test_bad_count();
    int  lens [3] = '{7, 9, 8};
    logic want [3] = '{1'b1, 1'b1, 1'b0};
    act_t a;
    clear_q();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < lens[r]; k++) shift_bit(3'($urandom));
      latch(4'd3, 2);
    end
    n_total++;
    if (act_q.size() != 3) begin
      $display("FAIL bad_count_n: got %0d records required 3", act_q.size());
      return;
    end
    n_pass++;
    for (int r = 0; r < 3; r++) begin
      a = act_q.pop_front();
      n_total++;
      if (a.bad !== want[r] || a.data !== exp_q[r].data)
        $display("FAIL bad_count%0d: got bad=%b required %b", lens[r], a.bad, want[r]);
      else n_pass++;
    end
    clear_q();
  endtask

  task automatic test_noe();
    act_t a;
    latch(4'd1, 2);
    clear_q();
    tick();
    hub_noe = 1'b0; repeat (40) tick();
    hub_noe = 1'b1; repeat (3) tick();
    latch(4'd1, 2);
    n_total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      $display("FAIL noe_count: got %0d records required 1", act_q.size());
      return;
    end
    n_pass++;
    a = act_q.pop_front();
    n_total++;
    if (a.on_a !== 16'd40 || exp_q[0].on != 40)
      $display("FAIL noe_on16: got %0d required 40", a.on_a);
    else n_pass++;
    n_total++;
    if (a.on_b !== 4'd15) $display("FAIL noe_on4_sat: got %0d required 15", a.on_b);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_simul();
    logic [2:0] last = 3'($urandom_range(1, 7));
    act_t a;
    clear_q();
    for (int k = 0; k < 7; k++) shift_bit(3'($urandom));
    s_in = last; hub_mux = 4'd7; hub_clk = 1'b1; hub_lat = 1'b1;
    tick(); tick();
    hub_clk = 1'b0;
    repeat (8) tick();
    hub_lat = 1'b0;
    repeat (3) tick();
    n_total++;
    if (act_q.size() != 1) begin
      $display("FAIL simul_one_record: got %0d records required 1", act_q.size());
      return;
    end
    n_pass++;
    a = act_q.pop_front();
    n_total++;
    if (a.data[2:0] !== last || a.bad !== 1'b0 || a.data !== exp_q[0].data)
      $display("FAIL simul_col0: got col0=%b bad=%b required col0=%b bad=0", a.data[2:0], a.bad, last);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_reset_mid();
    act_t a;
    clear_q();
    for (int k = 0; k < 4; k++) shift_bit(3'b111);
    rst_n = 1'b0; model_reset();
    repeat (2) tick();
    n_total++;
    if ({a_valid, a_data, a_row, a_slot, a_on, a_bad} !== '0)
      $display("FAIL reset_mid_outputs: got data=%h row=%h slot=%h required all zero", a_data, a_row, a_slot);
    else n_pass++;
    rst_n = 1'b1; tick();
    for (int k = 0; k < NC; k++) shift_bit(3'($urandom));
    latch(4'd5, 2);
    n_total++;
    if (act_q.size() != 1 || exp_q.size() != 1) begin
      $display("FAIL reset_mid_count: got %0d records required 1", act_q.size());
      return;
    end
    n_pass++;
    a = act_q.pop_front();
    n_total++;
    if (a.slot !== 4'd0 || a.bad !== 1'b0 || a.data !== exp_q[0].data)
      $display("FAIL reset_mid_rec: got slot=%0d bad=%b data=%h required 0 0 %h", a.slot, a.bad, a.data, exp_q[0].data);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_random();
    act_t a; exp_t e;
    int ea, eb;
    clear_q();
    noe_rand = 1;
    for (int r = 0; r < 20; r++) begin
      int len = $urandom_range(6, 10);
      for (int k = 0; k < len; k++) shift_bit(3'($urandom));
      repeat ($urandom_range(0, 20)) tick();
      latch(4'($urandom_range(0, 3)), $urandom_range(1, 4));
    end
    noe_rand = 0; hub_noe = 1'b1;
    repeat (3) tick();
    n_total++;
    if (act_q.size() != exp_q.size() || act_q.size() != 20) begin
      $display("FAIL random_count: got %0d records required %0d", act_q.size(), exp_q.size());
      return;
    end
    n_pass++;
    for (int r = 0; r < 20; r++) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      ea = (e.on > 65535) ? 65535 : e.on;
      eb = (e.on > 15) ? 15 : e.on;
      n_total++;
      if (a.data !== e.data || a.row !== e.row || a.slot !== e.slot || a.bad !== e.bad ||
          a.on_a !== 16'(ea) || a.on_b !== 4'(eb))
        $display("FAIL random_rec%0d: got data=%h row=%0d slot=%0d bad=%b on=%0d/%0d required data=%h row=%0d slot=%0d bad=%b on=%0d/%0d",
                 r, a.data, a.row, a.slot, a.bad, a.on_a, a.on_b, e.data, e.row, e.slot, e.bad, ea, eb);
      else n_pass++;
    end
  endtask

  initial begin
    noe_rand = 0;
    model_reset();
    test_reset();
    test_basic();
    test_slot();
    test_bad_count();
    test_noe();
    test_simul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
